// File: rtl/pc_pkg.sv
// pc_pkg: shared BTB entry layout, direction-counter encodings and fetch step.
package pc_pkg;
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;
  localparam logic [1:0] CTR_INIT = 2'b10;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    return up ? (c == STRONG_T ? c : c + 2'd1) : (c == STRONG_NT ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/pc_btb_array.sv
// pc_btb_array: fully associative BTB storage, lookup, training and round-robin replacement.
// PC_BTB_CNT2_EN selects 2-bit direction counters; otherwise every hit predicts taken.
module pc_btb_array
  import pc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc_i,
  input  logic        train_i,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] br_target_i,
  input  logic        br_taken_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o
);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef PC_BTB_CNT2_EN
  localparam logic [1:0] CTR_FILL = CTR_INIT;
`else
  localparam logic [1:0] CTR_FILL = STRONG_T;
`endif
  btb_entry_t entries_q [DEPTH];
  btb_entry_t entries_d [DEPTH];
  logic [IDX_W-1:0] rr_q, rr_d, lk_idx, tr_idx;
  logic lk_hit, tr_hit;
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    tr_hit = 1'b0;
    tr_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && entries_q[i].tag == lookup_pc_i) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (entries_q[i].valid && entries_q[i].tag == br_pc_i) begin
        tr_hit = 1'b1;
        tr_idx = IDX_W'(i);
      end
    end
  end
  // Lookup reads the pre-update array; training only affects the next cycle.
  assign pred_taken_o  = lk_hit & entries_q[lk_idx].ctr[1];
  assign pred_target_o = entries_q[lk_idx].target;
  always_comb begin
    entries_d = entries_q;
    rr_d = rr_q;
    if (train_i && tr_hit) begin
`ifdef PC_BTB_CNT2_EN
      entries_d[tr_idx].ctr = ctr_step(entries_q[tr_idx].ctr, br_taken_i);
`else
      entries_d[tr_idx].valid = br_taken_i;
`endif
      if (br_taken_i) entries_d[tr_idx].target = br_target_i;
    end else if (train_i && br_taken_i) begin
      entries_d[rr_q] = '{valid: 1'b1, tag: br_pc_i, target: br_target_i, ctr: CTR_FILL};
      rr_d = rr_q + IDX_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_FILL};
      rr_q <= '0;
    end else begin
      entries_q <= entries_d;
      rr_q <= rr_d;
    end
  end
endmodule

// File: rtl/pc_predict.sv
// pc_predict: fetch PC register with BTB-driven next-PC prediction and redirect priority.
// Optional 2-bit direction counters are enabled with PC_BTB_CNT2_EN.
module pc_predict
  import pc_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] except_addr_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] br_target_i,
  input  logic        br_taken_i,
  input  logic        br_mispred_i,
  output logic [31:0] pc_o,
  output logic        ena_o,
  output logic        pred_taken_o,
  output logic        flush_o
);
  logic [31:0] pc_q, pc_d, btb_target, pred_next;
  logic ena_q, ena_d, flush_q, flush_d, redirect;
  pc_btb_array #(.DEPTH(DEPTH)) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc_i  (pc_q),
    .train_i      (br_valid_i & ~flush_i),
    .br_pc_i      (br_pc_i),
    .br_target_i  (br_target_i),
    .br_taken_i   (br_taken_i),
    .pred_taken_o (pred_taken_o),
    .pred_target_o(btb_target)
  );
  // Redirects win over stall, so fetch is only disabled after a stall that actually held.
  always_comb begin
    redirect  = br_valid_i & br_mispred_i;
    pred_next = pred_taken_o ? btb_target : pc_q + PC_STEP;
    pc_d      = flush_i ? except_addr_i
              : redirect ? (br_taken_i ? br_target_i : br_pc_i + PC_STEP)
              : stall_i ? pc_q : pred_next;
    flush_d   = flush_i | redirect;
    ena_d     = ~stall_i | flush_i | redirect;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      ena_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ena_q   <= ena_d;
      flush_q <= flush_d;
    end
  end
  assign pc_o    = pc_q;
  assign ena_o   = ena_q;
  assign flush_o = flush_q;
endmodule

// File: tb/tb_pc_predict.sv
// tb_pc_predict: directed scenarios plus random traffic checked against a behavioural BTB model.
module tb_pc_predict;
  localparam int D = 4;
  localparam logic [31:0] RPC = 32'hBFC00000;
`ifdef PC_BTB_CNT2_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic stall_i = 0, flush_i = 0, br_valid_i = 0, br_taken_i = 0, br_mispred_i = 0;
  logic [31:0] except_addr_i = 0, br_pc_i = 0, br_target_i = 0;
  logic [31:0] pc_o;
  logic ena_o, pred_taken_o, flush_o;
  int checks = 0, errors = 0;
  bit m_v [D];
  logic [31:0] m_tag [D], m_tgt [D];
  int m_ctr [D];
  int m_rr;
  logic [31:0] m_pc;
  logic m_ena, m_flush;
  logic [31:0] saved;

  pc_predict #(.DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .except_addr_i(except_addr_i),
    .br_valid_i(br_valid_i), .br_pc_i(br_pc_i), .br_target_i(br_target_i), .br_taken_i(br_taken_i),
    .br_mispred_i(br_mispred_i), .pc_o(pc_o), .ena_o(ena_o), .pred_taken_o(pred_taken_o),
    .flush_o(flush_o)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int find(input logic [31:0] a);
    for (int i = 0; i < D; i++) if (m_v[i] && m_tag[i] == a) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_pc = RPC; m_ena = 0; m_flush = 0; m_rr = 0;
    for (int i = 0; i < D; i++) m_v[i] = 0;
  endtask

  // Compare DUT against the model, then advance the model and the clock by one cycle.
  task automatic tick();
    int h;
    bit pt, rd;
    logic [31:0] npc;
    #1;
    h = find(m_pc);
    pt = (h >= 0) && (!CNT || m_ctr[h] >= 2);
    chk("pc", pc_o, m_pc);
    chk("ena", 32'(ena_o), 32'(m_ena));
    chk("flush", 32'(flush_o), 32'(m_flush));
    chk("pred", 32'(pred_taken_o), 32'(pt));
    if (!rst) m_reset();
    else begin
      rd = br_valid_i && br_mispred_i;
      npc = flush_i ? except_addr_i : rd ? (br_taken_i ? br_target_i : br_pc_i + 32'd4)
          : stall_i ? m_pc : pt ? m_tgt[h] : m_pc + 32'd4;
      m_flush = flush_i || rd;
      m_ena = !(stall_i && !flush_i && !rd);
      if (br_valid_i && !flush_i) begin
        h = find(br_pc_i);
        if (h >= 0) begin
          if (CNT) m_ctr[h] = br_taken_i ? (m_ctr[h] < 3 ? m_ctr[h] + 1 : 3) : (m_ctr[h] > 0 ? m_ctr[h] - 1 : 0);
          else if (!br_taken_i) m_v[h] = 0;
          if (br_taken_i) m_tgt[h] = br_target_i;
        end else if (br_taken_i) begin
          m_v[m_rr] = 1; m_tag[m_rr] = br_pc_i; m_tgt[m_rr] = br_target_i; m_ctr[m_rr] = 2;
          m_rr = (m_rr + 1) % D;
        end
      end
      m_pc = npc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic [31:0] ea, input logic bv,
                       input logic [31:0] bpc, input logic [31:0] bt, input logic tk, input logic mp);
    stall_i = st; flush_i = fl; except_addr_i = ea; br_valid_i = bv;
    br_pc_i = bpc; br_target_i = bt; br_taken_i = tk; br_mispred_i = mp;
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go(input logic [31:0] a);
    drive(0, 1, a, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_pc", pc_o, RPC);
    chk("rst_ena", 32'(ena_o), 0);
    chk("rst_flush", 32'(flush_o), 0);
    idle();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("seq_pc", pc_o, RPC + 32'(4 * k));
      chk("seq_pred", 32'(pred_taken_o), 0);
      idle();
    end
    drive(0, 0, 0, 1, 32'hBFC00010, 32'hBFC00100, 1, 1);
    chk("mp_pc", pc_o, 32'hBFC00100);
    chk("mp_flush", 32'(flush_o), 1);
    idle();
    chk("mp_flush_end", 32'(flush_o), 0);
    go(32'hBFC00010);
    chk("hit_pred", 32'(pred_taken_o), 1);
    idle();
    chk("hit_next", pc_o, 32'hBFC00100);
    drive(0, 0, 0, 1, 32'hBFC00010, 32'hBFC00100, 0, 0);
    drive(0, 0, 0, 1, 32'hBFC00010, 32'hBFC00100, 0, 0);
    go(32'hBFC00010);
    chk("nt_pred", 32'(pred_taken_o), 0);
    idle();
    for (int k = 0; k <= D; k++) drive(0, 0, 0, 1, 32'h1000 + 32'(16 * k), 32'h8000 + 32'(16 * k), 1, 0);
    go(32'h1000);
    chk("evict_miss", 32'(pred_taken_o), 0);
    go(32'h1000 + 32'(16 * D));
    chk("newest_hit", 32'(pred_taken_o), 1);
    idle();
    chk("newest_tgt", pc_o, 32'h8000 + 32'(16 * D));
    drive(1, 1, 32'hBFC00380, 1, 32'h5000, 32'h6000, 1, 1);
    chk("fl_pc", pc_o, 32'hBFC00380);
    chk("fl_flush", 32'(flush_o), 1);
    go(32'h5000);
    chk("fl_no_train", 32'(pred_taken_o), 0);
    idle();
    saved = pc_o;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("st_hold", pc_o, saved);
    chk("st_ena", 32'(ena_o), 0);
    drive(1, 0, 0, 1, 32'h7000, 32'h7100, 1, 1);
    chk("st_redir", pc_o, 32'h7100);
    chk("st_redir_ena", 32'(ena_o), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("st_hold2", pc_o, 32'h7100);
    chk("st_ena2", 32'(ena_o), 0);
    go(32'hFFFFFFFC);
    idle();
    chk("wrap", pc_o, 32'h0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      a = 32'h2000 + 32'(4 * $urandom_range(0, 5));
      b = 32'h2000 + 32'(4 * $urandom_range(0, 7));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 32'h2000 + 32'(4 * $urandom_range(0, 5)),
            $urandom_range(0, 1) == 1, a, b, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
